// File: rtl/aes_pkg.sv
`default_nettype none
// aes_pkg: shared GF(2^8) constants, state/FSM types and xtime helper for the (Inv)MixColumns engine.
// Rev 1.0
package aes_pkg;

  localparam logic [7:0] AES_POLY  = 8'h1B;

  localparam logic [7:0] INV_COEF0 = 8'h0E;
  localparam logic [7:0] INV_COEF1 = 8'h0B;
  localparam logic [7:0] INV_COEF2 = 8'h0D;
  localparam logic [7:0] INV_COEF3 = 8'h09;

  localparam logic [7:0] FWD_COEF0 = 8'h02;
  localparam logic [7:0] FWD_COEF1 = 8'h03;
  localparam logic [7:0] FWD_COEF2 = 8'h01;
  localparam logic [7:0] FWD_COEF3 = 8'h01;

  typedef logic [127:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  // k is the circulant offset (input byte index minus output row, mod 4)
  function automatic logic [7:0] coef_sel(input int k, input logic fwd);
    logic [7:0] c;
    c = 8'h00;
    case (k)
      0: c = fwd ? FWD_COEF0 : INV_COEF0;
      1: c = fwd ? FWD_COEF1 : INV_COEF1;
      2: c = fwd ? FWD_COEF2 : INV_COEF2;
      3: c = fwd ? FWD_COEF3 : INV_COEF3;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_mul_const.sv
`default_nettype none
// gf_mul_const: combinational byte x coefficient multiply over GF(2^8) for {01,02,03,09,0B,0D,0E}.
// Rev 1.0
module gf_mul_const
  import aes_pkg::*;
(
  input  logic [7:0] b,
  input  logic [7:0] coef,
  output logic [7:0] p
);

  logic [7:0] x2, x4, x8;

  assign x2 = xtime(b);
  assign x4 = xtime(x2);
  assign x8 = xtime(x4);

  always_comb begin
    p = 8'h00;
    case (coef)
      8'h01:   p = b;
      8'h02:   p = x2;
      8'h03:   p = x2 ^ b;
      8'h09:   p = x8 ^ b;
      8'h0B:   p = x8 ^ x2 ^ b;
      8'h0D:   p = x8 ^ x4 ^ b;
      8'h0E:   p = x8 ^ x4 ^ x2;
      default: p = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/inv_mix_columns_seq.sv
`default_nettype none
// inv_mix_columns_seq: iterative AES InvMixColumns, one column per cycle, valid/ready in and out.
// Define INV_MIX_FORWARD_EN to add a mode port selecting forward MixColumns. Rev 1.0
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
`ifdef INV_MIX_FORWARD_EN
  input  logic         mode,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  state_t     state, state_nxt;
  logic [1:0] col_cnt;
  aes_state_t work;
  logic       fwd;
  logic [31:0] col_in, col_out;
  logic [7:0] prod [4][4];

`ifdef INV_MIX_FORWARD_EN
  logic mode_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   mode_q <= 1'b0;
    else if (in_valid && in_ready) mode_q <= mode;
  end
  assign fwd = mode_q;
`else
  assign fwd = 1'b0;
`endif

  always_comb begin
    col_in = 32'h0;
    case (col_cnt)
      2'd0: col_in = work[127:96];
      2'd1: col_in = work[95:64];
      2'd2: col_in = work[63:32];
      2'd3: col_in = work[31:0];
      default: col_in = 32'h0;
    endcase
  end

  // Circulant matrix: output row r takes input byte j with coefficient index (j - r) mod 4
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar j = 0; j < 4; j++) begin : g_term
      gf_mul_const u_mul (
        .b    (col_in[31-8*j -: 8]),
        .coef (coef_sel((j - r + 4) % 4, fwd)),
        .p    (prod[r][j])
      );
    end
    assign col_out[31-8*r -: 8] = prod[r][0] ^ prod[r][1] ^ prod[r][2] ^ prod[r][3];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)                 state_nxt = BUSY;
      BUSY:    if (col_cnt == 2'd3)          state_nxt = DONE;
      DONE:    if (out_ready)                state_nxt = IDLE;
      default:                               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      col_cnt <= 2'd0;
      work    <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        work    <= in_data;
        col_cnt <= 2'd0;
      end else if (state == BUSY) begin
        case (col_cnt)
          2'd0: work[127:96] <= col_out;
          2'd1: work[95:64]  <= col_out;
          2'd2: work[63:32]  <= col_out;
          2'd3: work[31:0]   <= col_out;
          default: ;
        endcase
        col_cnt <= col_cnt + 2'd1;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_seq.sv
`default_nettype none
// tb_inv_mix_columns_seq: directed and randomized checks against a GF(2^8) matrix reference model.
// Rev 1.0
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
`ifdef INV_MIX_FORWARD_EN
  logic         mode;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef INV_MIX_FORWARD_EN
    .mode      (mode),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain shift-and-add GF(2^8) multiply and the literal AES matrices
  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit fwd);
    logic [7:0] inv_m [4][4];
    logic [7:0] fwd_m [4][4];
    logic [127:0] res;
    logic [7:0] acc, coef;
    inv_m = '{'{8'h0E, 8'h0B, 8'h0D, 8'h09}, '{8'h09, 8'h0E, 8'h0B, 8'h0D},
              '{8'h0D, 8'h09, 8'h0E, 8'h0B}, '{8'h0B, 8'h0D, 8'h09, 8'h0E}};
    fwd_m = '{'{8'h02, 8'h03, 8'h01, 8'h01}, '{8'h01, 8'h02, 8'h03, 8'h01},
              '{8'h01, 8'h01, 8'h02, 8'h03}, '{8'h03, 8'h01, 8'h01, 8'h02}};
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          coef = fwd ? fwd_m[r][j] : inv_m[r][j];
          acc = acc ^ gmul(coef, s[127-32*c-8*j -: 8]);
        end
        res[127-32*c-8*r -: 8] = acc;
      end
    return res;
  endfunction

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 128'(n), 128'd4);
  endtask

  task automatic run_block(input logic [127:0] d, input logic [127:0] exp, input bit fwd, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_rdy"}, 128'(in_ready), 128'd1);
    in_data = d; in_valid = 1'b1;
`ifdef INV_MIX_FORWARD_EN
    mode = fwd;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(tag);
    check({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ovdrop"}, 128'(out_valid), 128'd0);
  endtask

  localparam logic [127:0] FULL_IN  = 128'h8E4DA1BC_9FDC589D_01010101_C6C6C6C6;
  localparam logic [127:0] FULL_OUT = 128'hDB135345_F20A225C_01010101_C6C6C6C6;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] d, exp;
    logic [127:0] blk [3];
    logic [127:0] exp_q [$];
    int acc_cyc [3];
    int out_cyc [3];
    int idx, nout, cyc;
    bit acc, outh;
    logic [127:0] od;
    bit fwd;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
`ifdef INV_MIX_FORWARD_EN
    mode = 1'b0;
`endif
    #12;
    check("rst_ov", 128'(out_valid), 128'd0);
    check("rst_od", out_data, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", 128'(in_ready), 128'd1);

    run_block({32'h8E4DA1BC, 96'h0}, {32'hDB135345, 96'h0}, 1'b0, "single_col");
    run_block(FULL_IN, FULL_OUT, 1'b0, "full_blk");

    // Backpressure with a competing input already pending
    in_data = FULL_IN; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out("bp");
    d = {$urandom, $urandom, $urandom, $urandom};
    in_data = d; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_data", out_data, FULL_OUT);
      check("bp_rdy", 128'(in_ready), 128'd0);
      @(posedge clk); #1;
    end
    check("bp_ov", 128'(out_valid), 128'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_idle", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_acc", 128'(in_ready), 128'd0);
    wait_out("bp2");
    check("bp2_data", out_data, ref_mix(d, 1'b0));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Asynchronous reset after two columns
    in_data = FULL_IN; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0; #1;
    check("mid_rst_ov", 128'(out_valid), 128'd0);
    check("mid_rst_od", out_data, 128'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_rdy", 128'(in_ready), 128'd1);
    repeat (5) @(posedge clk);
    #1;
    check("mid_rst_quiet", 128'(out_valid), 128'd0);
    run_block({4{32'hD5D5D7D6}}, {4{32'hD4D4D4D5}}, 1'b0, "post_rst");

`ifdef INV_MIX_FORWARD_EN
    run_block({32'hDB135345, 96'h0}, {32'h8E4DA1BC, 96'h0}, 1'b1, "fwd_col");
    run_block(FULL_IN, FULL_OUT, 1'b0, "fwd_inv");
`endif

    for (int k = 0; k < 20; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
`ifdef INV_MIX_FORWARD_EN
      fwd = bit'($urandom_range(0, 1));
`else
      fwd = 1'b0;
`endif
      run_block(d, ref_mix(d, fwd), fwd, "rand");
    end

    // Back-to-back: in_valid held, out_ready held
    for (int k = 0; k < 3; k++) begin
      blk[k] = {$urandom, $urandom, $urandom, $urandom};
      exp_q.push_back(ref_mix(blk[k], 1'b0));
    end
`ifdef INV_MIX_FORWARD_EN
    mode = 1'b0;
`endif
    idx = 0; nout = 0; cyc = 0;
    in_data = blk[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (nout < 3 && cyc < 60) begin
      acc = in_valid && in_ready;
      outh = out_valid && out_ready;
      od = out_data;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 3) in_data = blk[idx];
        else         in_valid = 1'b0;
      end
      if (outh) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        check("b2b_data", od, exp);
        out_cyc[nout] = cyc;
        nout++;
      end
    end
    in_valid = 1'b0;
    check("b2b_nout", 128'(nout), 128'd3);
    check("b2b_nacc", 128'(idx), 128'd3);
    if (idx == 3 && nout == 3) begin
      check("b2b_sp1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd6);
      check("b2b_sp2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd6);
      check("b2b_lat", 128'(out_cyc[0] - acc_cyc[0]), 128'd5);
    end
    repeat (8) @(posedge clk);
    #1;
    check("b2b_nodup", 128'(out_valid), 128'd0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
